led_chaser: RTL and testbench
=============================

Name: led_chaser

Overview:
- Parametrised LED pattern engine for the board LED bank.
- An internal prescaler produces a step tick every TICK_CYCLES enabled clocks.
- On each tick the WIDTH-bit pattern register advances according to a runtime-selected mode: rotate left, rotate right, bounce (ping-pong), or hold.
- Sits between the top-level clock and the LED pins; a parallel load lets software or switches seed any pattern.

Parameters:
- WIDTH, 8: number of LEDs / pattern bits. Legal range: 2 or more.
- TICK_CYCLES, 50000000: clock cycles per step. Legal range: 1 or more.
- CNT_W, $clog2(TICK_CYCLES) (minimum 1): prescaler counter width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  when 1, prescaler advances; when 0, prescaler and pattern freeze
- mode  in  2  00 rotate left, 01 rotate right, 10 bounce, 11 hold
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  pattern to load
- led  out  WIDTH  current pattern (registered)
- tick  out  1  registered one-cycle pulse; high in the cycle in which led first shows a stepped value
- dir  out  1  bounce direction: 0 = toward MSB, 1 = toward LSB (registered)

Behaviour:
- Reset (rst_n low, async): led = 1 (only bit0 set), prescaler = 0, tick = 0, dir = 0. Outputs hold these values while rst_n is low. The first step occurs TICK_CYCLES enabled cycles after release.
- Reset mid-operation: all state clears immediately, regardless of en, load or an in-flight count.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 while en=1.
  - At the rising edge where count == TICK_CYCLES-1 and en=1: count wraps to 0, led takes the next pattern, tick is set to 1. On all other edges tick is set to 0.
  - TICK_CYCLES=1: tick stays high on every enabled cycle.
- en=0: count, led and dir hold; tick is 0. Counting resumes from the held value.
- Step rules, applied on a tick edge only:
  - Rotate left: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
  - Rotate right: led <= {led[0], led[WIDTH-1:1]}.
  - Bounce: logical shift with zero fill.
    - dir=0 and led[WIDTH-1]=1: dir <= 1, shift right.
    - dir=1 and led[0]=1: dir <= 0, shift left.
    - Otherwise: shift left if dir=0, shift right if dir=1.
    - From a single set bit the period is 2*(WIDTH-1) ticks, and no end position repeats.
  - Hold: led unchanged. tick still pulses and the prescaler still runs.
- dir changes only in bounce mode. It is retained across mode changes.
- A mode change takes effect at the next tick. There is no extra latency and the prescaler is not restarted.
- Load (priority over tick and en): at the edge with load=1, led <= load_val, count <= 0, dir <= 0, tick <= 0. The next step occurs TICK_CYCLES enabled cycles later.
- load_val = 0: led stays 0 in every mode. This is legal.
- Multi-bit patterns in bounce:
  - Reflection is decided by the end bits only, so bits may be lost off the far end during a shift.
  - This is the defined behaviour; no fault is raised.
- Simultaneous load and prescaler wrap: load wins and the tick is dropped.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings: MODE_ROT_L = 2'b00, MODE_ROT_R = 2'b01, MODE_BOUNCE = 2'b10, MODE_HOLD = 2'b11;
  - reset pattern constant LED_RST_BIT0.
- One sub-module, tick_prescaler:
  - parameter TICK_CYCLES;
  - ports clk, rst_n, en, clr, tick_pre;
  - tick_pre is the combinational wrap condition.
- led_chaser registers the tick output and owns the pattern and dir registers plus the next-pattern mux.

Test Plan (WIDTH=8, TICK_CYCLES=4 unless noted):
- Reset and rotate left: release rst_n with en=1, mode=00 -> led=0x01 during reset; 0x02 with tick=1 at cycle 4; 0x04 at cycle 8; after 8 ticks back to 0x01 (wrap from 0x80 to 0x01).
- Rotate right with wrap: load 0x01, mode=01 -> ticks give 0x80, 0x40, 0x20; tick is high exactly 1 cycle in 4.
- Bounce, WIDTH=4: from 0001 -> 0010, 0100, 1000, 0100, 0010, 0001, 0010; dir=1 first appears in the cycle led shows 0100 after 1000; period is 6 ticks.
- en gating and hold: deassert en for 10 cycles mid-count -> led, count and dir frozen, tick=0, count resumes; mode=11 -> tick keeps pulsing and led stays constant.
- Load priority: load=1 with load_val=0xA5 on a wrap edge -> led=0xA5, tick=0, next step 4 cycles later giving 0x4B in rotate left; load_val=0x00 -> led stays 0x00 in every mode.
- Async reset mid-bounce: drop rst_n between clock edges with led=0x10, dir=1 -> led=0x01, dir=0, tick=0 immediately without waiting for a clock; normal stepping resumes after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED chaser: mode encodings and the reset pattern seed.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Value of bit0 after reset; all higher bits reset to zero.
  localparam logic LED_RST_BIT0 = 1'b1;

endpackage

// File: rtl/led_chaser_tick_prescaler.sv
// Step-rate prescaler: counts enabled clocks and flags the wrap cycle combinationally.
module tick_prescaler #(
  parameter int TICK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_pre
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign tick_pre = en && (count_reg == CNT_LAST);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (tick_pre) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED pattern engine: steps the pattern register on each prescaler tick using the selected mode.
module led_chaser
  import led_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir
);

  localparam logic [WIDTH-1:0] LED_RST = {{(WIDTH-1){1'b0}}, LED_RST_BIT0};

  logic             tick_pre;
  logic [WIDTH-1:0] led_reg;
  logic [WIDTH-1:0] led_next;
  logic             dir_reg;
  logic             dir_next;
  logic             tick_reg;

  // A load restarts the step interval, so it also clears the prescaler.
  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .tick_pre (tick_pre)
  );

  // Stepped pattern, only consumed on a tick edge.
  always_comb begin
    led_next = led_reg;
    dir_next = dir_reg;
    unique case (mode)
      MODE_ROT_L: led_next = {led_reg[WIDTH-2:0], led_reg[WIDTH-1]};
      MODE_ROT_R: led_next = {led_reg[0], led_reg[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // Reflection looks at the end bit only; inner bits may fall off.
        if (!dir_reg && led_reg[WIDTH-1]) begin
          dir_next = 1'b1;
          led_next = {1'b0, led_reg[WIDTH-1:1]};
        end else if (dir_reg && led_reg[0]) begin
          dir_next = 1'b0;
          led_next = {led_reg[WIDTH-2:0], 1'b0};
        end else if (!dir_reg) begin
          led_next = {led_reg[WIDTH-2:0], 1'b0};
        end else begin
          led_next = {1'b0, led_reg[WIDTH-1:1]};
        end
      end
      default: led_next = led_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg  <= LED_RST;
      dir_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else if (load) begin
      led_reg  <= load_val;
      dir_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else if (tick_pre) begin
      led_reg  <= led_next;
      dir_reg  <= dir_next;
      tick_reg <= 1'b1;
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign led  = led_reg;
  assign dir  = dir_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_led_chaser.sv
// Randomised scoreboard bench for led_chaser (WIDTH=8, TICK_CYCLES=4).
module tb_led_chaser;

  localparam int W = 8;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] led;
  logic         tick;
  logic         dir;

  led_chaser #(.WIDTH(W), .TICK_CYCLES(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .tick     (tick),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] led;
    logic         dir;
    int           edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: pattern as an integer, enabled-cycle phase within a step.
  int           m_cnt = 0;
  logic [W-1:0] m_led = 8'h01;
  logic         m_dir = 1'b0;

  function automatic void chk(string nm, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  function automatic void m_step(input logic [1:0] md);
    int v;
    v = int'(m_led);
    case (md)
      2'd0: v = ((v * 2) + (v / 128)) % 256;
      2'd1: v = (v / 2) + ((v % 2) * 128);
      2'd2: begin
        if (!m_dir && v >= 128) begin
          m_dir = 1'b1; v = v / 2;
        end else if (m_dir && (v % 2) == 1) begin
          m_dir = 1'b0; v = (v * 2) % 256;
        end else if (!m_dir) begin
          v = (v * 2) % 256;
        end else begin
          v = v / 2;
        end
      end
      default: ;
    endcase
    m_led = v[W-1:0];
  endfunction

  task automatic cyc(input logic e, input logic [1:0] md, input logic ld, input logic [W-1:0] lv);
    exp_t x;
    @(negedge clk);
    en = e; mode = md; load = ld; load_val = lv;
    if (ld) begin
      m_led = lv; m_cnt = 0; m_dir = 1'b0;
    end else if (e) begin
      if (m_cnt == T - 1) begin
        m_cnt = 0;
        m_step(md);
        x.led = m_led; x.dir = m_dir; x.edge_n = edge_cnt + 1;
        exp_q.push_back(x);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic run(input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) cyc(1'b1, md, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_led"}, int'(led), 1);
    chk({tag, "_dir"}, int'(dir), 0);
    chk({tag, "_tick"}, int'(tick), 0);
  endtask

  // Drops rst_n between edges, checks the immediate clear, then releases with en low.
  task automatic async_reset(input int hold_cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0; load = 1'b0;
    #1;
    check_reset_state("async_rst");
    m_led = 8'h01; m_dir = 1'b0; m_cnt = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check_reset_state("rst_hold");
    end
    rst_n = 1'b1;
  endtask

  // Monitor: every tick pulse must match the oldest predicted step.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", edge_cnt, -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tick_edge", edge_cnt, e.edge_n);
        chk("step_led", int'(led), int'(e.led));
        chk("step_dir", int'(dir), int'(e.dir));
      end
    end
  end

  initial begin
    int i;
    // Reset held, then released with en low.
    repeat (3) begin
      @(negedge clk);
      check_reset_state("por");
    end
    rst_n = 1'b1;

    // Rotate left from reset through a full wrap.
    run(40, 2'b00);
    // Rotate right with wrap.
    cyc(1'b1, 2'b01, 1'b1, 8'h01);
    run(20, 2'b01);
    // Bounce, two full periods.
    cyc(1'b1, 2'b10, 1'b1, 8'h01);
    run(4 * 30, 2'b10);
    // en gating mid-count.
    run(2, 2'b10);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'b10, 1'b0, '0);
      chk("en_off_tick", int'(tick), 0);
    end
    run(12, 2'b10);
    // Hold: ticks keep pulsing, pattern stays.
    run(16, 2'b11);
    // Load on a wrap edge wins over the tick.
    i = 0;
    while (m_cnt != T - 1 && i < 10) begin
      cyc(1'b1, 2'b00, 1'b0, '0);
      i++;
    end
    cyc(1'b1, 2'b00, 1'b1, 8'hA5);
    @(posedge clk); #1;
    chk("load_wrap_led", int'(led), 8'hA5);
    chk("load_wrap_tick", int'(tick), 0);
    run(10, 2'b00);
    // Zero pattern stays zero in every mode.
    cyc(1'b1, 2'b00, 1'b1, 8'h00);
    for (int md = 0; md < 4; md++) run(9, md[1:0]);
    // Walk bounce to 0x10 heading toward LSB, then reset asynchronously.
    cyc(1'b1, 2'b10, 1'b1, 8'h01);
    i = 0;
    while (!(m_led == 8'h10 && m_dir) && i < 200) begin
      cyc(1'b1, 2'b10, 1'b0, '0);
      i++;
    end
    chk("reach_0x10_dir1", i < 200 ? 1 : 0, 1);
    async_reset(2);
    run(12, 2'b00);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 3), 8'($urandom));
      if (k == 700) begin
        async_reset(1);
      end
    end
    cyc(1'b0, 2'b11, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
